// File: rtl/mio_responder.sv
// Memory/IO responder: answers one CPU read or write at a time from a word RAM or a small IO
// register file, with a programmable wait and a one-cycle mio_ready completion pulse.
module mio_responder #(
    parameter int RAM_AW  = 10,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mio_ready,
    input  logic [7:0]  sw,
    output logic [7:0]  led,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0]  RD_LOAD  = 4'(RD_WAIT - 1);
    localparam logic [3:0]  WR_LOAD  = 4'(WR_WAIT - 1);
    localparam logic [31:0] ADDR_SW  = 32'hF000_0000;
    localparam logic [31:0] ADDR_CNT = 32'hF000_0004;

    state_t              state;
    state_t              next_state;
    logic [3:0]          wait_cnt;
    logic [31:0]         cap_addr;
    logic [31:0]         cap_wdata;
    logic                cap_rd;
    logic                cap_wr;
    logic [31:0]         cycle_cnt;
    logic [31:0]         ram [2**RAM_AW];

    logic                start;
    logic                fire;
    logic                aligned;
    logic                both;
    logic                is_ram;
    logic                is_sw;
    logic                is_cnt;
    logic                bad;
    logic                ram_we;
    logic                led_we;
    logic [RAM_AW-1:0]   ram_idx;
    logic [31:0]         rd_value;

    assign start = (state == S_IDLE) && (mem_r || mem_w);
    assign fire  = (state == S_WAIT) && (wait_cnt == 4'd0);

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  if (mem_r || mem_w) next_state = S_WAIT;
            S_WAIT:  if (wait_cnt == 4'd0) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mio_ready = (state == S_DONE);
        busy      = (state != S_IDLE);
    end

    // Request capture and wait counter; the captured copy is authoritative for the whole transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_rd    <= 1'b0;
            cap_wr    <= 1'b0;
            wait_cnt  <= '0;
        end else if (start) begin
            cap_addr  <= addr;
            cap_wdata <= wdata;
            cap_rd    <= mem_r;
            cap_wr    <= mem_w;
            wait_cnt  <= mem_r ? RD_LOAD : WR_LOAD;
        end else if (state == S_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // ---------------- Address decode of the captured request ----------------
    always_comb begin
        aligned = (cap_addr[1:0] == 2'b00);
        both    = cap_rd && cap_wr;
        is_ram  = (cap_addr[31:28] == 4'h0);
        is_sw   = (cap_addr == ADDR_SW);
        is_cnt  = (cap_addr == ADDR_CNT);
        ram_idx = cap_addr[RAM_AW+1:2];
        bad     = both || !aligned || !(is_ram || is_sw || is_cnt);
        ram_we  = fire && cap_wr && !cap_rd && aligned && is_ram;
        led_we  = fire && cap_wr && !cap_rd && is_sw;
    end

    always_comb begin
        rd_value = '0;
        if (!both && aligned) begin
            if (is_ram) begin
                rd_value = ram[ram_idx];
            end else if (is_sw) begin
                rd_value = {24'b0, sw};
            end else if (is_cnt) begin
                rd_value = cycle_cnt;
            end
        end
    end

    // NOTE: the RAM array has no reset; clearing it would block RAM inference and its contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= cap_wdata;
        end
    end

    // Read data, LED register and sticky error all commit on the edge entering DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
            led   <= '0;
            err   <= 1'b0;
        end else begin
            if (fire && cap_rd) begin
                rdata <= rd_value;
            end
            if (led_we) begin
                led <= cap_wdata[7:0];
            end
            if (fire && bad) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_mio_responder.sv
// Scoreboard bench for mio_responder: stimulus pushes expected completions (cycle and data),
// a negedge monitor pops and compares on every mio_ready pulse.
module tb_mio_responder;

    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 1;

    logic        clk;
    logic        reset;
    logic        mem_r;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mio_ready;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic        busy;
    logic        err;

    mio_responder #(.RAM_AW(10), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_r     (mem_r),
        .mem_w     (mem_w),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .mio_ready (mio_ready),
        .sw        (sw),
        .led       (led),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic [31:0] data;
        int unsigned due;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        prev_ready = 1'b0;

    // Edges since reset release; also equals the DUT cycle counter sampled at the next edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (mio_ready) begin
            exp_t e;
            check("ready_gap", {31'b0, prev_ready}, 32'd0);
            check("sb_has_entry", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.tag, "_lat"}, e.due == 0 ? 32'hFFFF_FFFF : cyc, e.due);
                if (e.chk) check({e.tag, "_rdata"}, rdata, e.data);
            end
        end
        prev_ready = mio_ready;
    end

    task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic chk, input logic [31:0] exp, input bit cnt_rd, input bit push,
                         input string tag, output int unsigned due);
        exp_t e;
        @(negedge clk);
        mem_r = r;
        mem_w = w;
        addr  = a;
        wdata = d;
        due   = cyc + 1 + (r ? RD_WAIT : WR_WAIT);
        if (push) begin
            e.chk  = chk;
            e.data = cnt_rd ? 32'(due - 1) : exp;
            e.due  = due;
            e.tag  = tag;
            sb.push_back(e);
        end
    endtask

    task automatic wait_ready(input string tag, input bit release_req);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = mio_ready;
        end
        check({tag, "_done"}, {31'b0, seen}, 32'd1);
        if (release_req) begin
            mem_r = 1'b0;
            mem_w = 1'b0;
        end
    endtask

    task automatic xfer(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic chk, input logic [31:0] exp, input bit cnt_rd, input string tag);
        int unsigned due;
        issue(r, w, a, d, chk, exp, cnt_rd, 1'b1, tag, due);
        wait_ready(tag, 1'b1);
    endtask

    initial begin
        int unsigned due;
        int          busy_cnt;
        int          stray;
        exp_t        e;

        reset = 1'b0;
        mem_r = 1'b0;
        mem_w = 1'b0;
        addr  = '0;
        wdata = '0;
        sw    = 8'h3C;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, mio_ready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_led",   {24'b0, led}, 32'd0);
        check("rst_busy",  {31'b0, busy}, 32'd0);
        check("rst_err",   {31'b0, err}, 32'd0);
        reset = 1'b1;

        // Preload RAM[0] through the port, then the first read with busy accounting.
        xfer(1'b0, 1'b1, 32'h0, 32'h1234_5678, 1'b0, 32'h0, 1'b0, "wr_ram0");
        issue(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b1, "rd_ram0", due);
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            busy_cnt += busy ? 1 : 0;
            if (mio_ready) mem_r = 1'b0;
        end
        check("busy_cycles", busy_cnt, 32'd3);

        xfer(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, "wr_10");
        xfer(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, "rd_10");
        check("err_clean", {31'b0, err}, 32'd0);

        xfer(1'b0, 1'b1, 32'hF000_0000, 32'h0000_00A5, 1'b0, 32'h0, 1'b0, "wr_led");
        check("led_val", {24'b0, led}, 32'h0000_00A5);
        xfer(1'b1, 1'b0, 32'hF000_0000, 32'h0, 1'b1, 32'h0000_003C, 1'b0, "rd_sw");

        for (int i = 0; i < 3; i++) begin
            xfer(1'b1, 1'b0, 32'hF000_0004, 32'h0, 1'b1, 32'h0, 1'b1, "rd_cnt");
        end
        xfer(1'b0, 1'b1, 32'hF000_0004, 32'h5A5A_5A5A, 1'b0, 32'h0, 1'b0, "wr_cnt");
        check("err_after_cnt_wr", {31'b0, err}, 32'd0);

        // Error paths: misaligned read, simultaneous read+write, unmapped read.
        xfer(1'b1, 1'b0, 32'h0000_0002, 32'h0, 1'b1, 32'h0, 1'b0, "rd_misal");
        check("err_misal", {31'b0, err}, 32'd1);
        xfer(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0, "rw_both");
        check("err_sticky", {31'b0, err}, 32'd1);
        xfer(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, "rd_ram0_kept");
        xfer(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0, 1'b0, "rd_unmapped");

        // Request dropped and address changed during WAIT: captured write still completes.
        issue(1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0, 1'b1, "wr_20_drop", due);
        @(negedge clk);
        mem_w = 1'b0;
        addr  = 32'h0000_0000;
        wdata = 32'h1111_1111;
        wait_ready("wr_20_drop", 1'b1);
        xfer(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0, "rd_20");
        xfer(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, "rd_ram0_after_drop");

        // Reset during WAIT: no pulse, no RAM write, LED and err cleared.
        issue(1'b0, 1'b1, 32'h20, 32'h5555_AAAA, 1'b0, 32'h0, 1'b0, 1'b0, "wr_20_rst", due);
        @(negedge clk);
        reset = 1'b0;
        mem_w = 1'b0;
        stray = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            stray += mio_ready ? 1 : 0;
        end
        check("rst_no_pulse", stray, 32'd0);
        check("rst_led_clr", {24'b0, led}, 32'd0);
        check("rst_err_clr", {31'b0, err}, 32'd0);
        xfer(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0, "rd_20_after_rst");

        // Fetch stream: mem_r held high, one completion every RD_WAIT+2 cycles.
        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, "fetch", due);
        for (int k = 1; k < 4; k++) begin
            e.chk  = 1'b1;
            e.data = 32'hDEAD_BEEF;
            e.due  = due + k * (RD_WAIT + 2);
            e.tag  = "fetch";
            sb.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            wait_ready("fetch", k == 3);
        end

        repeat (10) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
